// File: rtl/main_mem_responder.sv
// Line-granular main-memory model behind the cache refill port.
// Accepts one read or write line request, waits a fixed latency, then bursts data or acks.
module main_mem_responder #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned LATENCY    = 3,
   parameter logic [31:0] INIT_WORD  = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] wdata,
   input  logic        wdata_valid,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_last,
   output logic        busy
);

   localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
   localparam int unsigned LW_LOG2 = $clog2(LINE_WORDS);
   localparam int unsigned LAT_W   = $clog2(LATENCY + 1);
   localparam logic [LW_LOG2-1:0]    LAST_BEAT = LW_LOG2'(LINE_WORDS - 1);
   localparam logic [LAT_W-1:0]      LAT_INIT  = LAT_W'(LATENCY - 1);
   localparam logic [DEPTH_LOG2-1:0] LINE_MASK = ~DEPTH_LOG2'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DATA,
      S_WAIT,
      S_RD_BURST,
      S_WR_ACK
   } state_t;

   // Contents survive reset; only the power-up image is defined.
   logic [31:0] r_mem [DEPTH] = '{default: INIT_WORD};

   state_t                r_state;
   logic [DEPTH_LOG2-1:0] r_base;
   logic                  r_wr;
   logic [LW_LOG2-1:0]    r_beat;
   logic [LAT_W-1:0]      r_lat;

   logic [DEPTH_LOG2-1:0] w_acc_base;
   logic [LW_LOG2-1:0]    w_next_beat;
   logic [DEPTH_LOG2-1:0] w_beat_addr;
   logic [DEPTH_LOG2-1:0] w_next_addr;
   logic                  w_we;
   logic                  w_unused;

   // Upper address bits alias and the byte offset is dropped.
   assign w_acc_base  = req_addr[DEPTH_LOG2+1:2] & LINE_MASK;
   assign w_unused    = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
   assign w_next_beat = r_beat + LW_LOG2'(1);
   assign w_beat_addr = r_base | DEPTH_LOG2'(r_beat);
   assign w_next_addr = r_base | DEPTH_LOG2'(w_next_beat);
   assign w_we        = (r_state == S_WR_DATA) && wdata_valid;

   assign req_ready = (r_state == S_IDLE) && !rst;
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_beat_addr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_wr       <= 1'b0;
         r_beat     <= '0;
         r_lat      <= '0;
         resp_valid <= 1'b0;
         resp_last  <= 1'b0;
         resp_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_base <= w_acc_base;
                  r_wr   <= req_wr;
                  r_beat <= '0;
                  if (req_wr) begin
                     r_state <= S_WR_DATA;
                  end else begin
                     r_lat   <= LAT_INIT;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WR_DATA: begin
               if (wdata_valid) begin
                  r_beat <= w_next_beat;
                  if (r_beat == LAST_BEAT) begin
                     r_lat   <= LAT_INIT;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // First response beat is registered on the edge the counter is seen at zero.
               if (r_lat == '0) begin
                  resp_valid <= 1'b1;
                  if (r_wr) begin
                     resp_last <= 1'b1;
                     resp_data <= '0;
                     r_state   <= S_WR_ACK;
                  end else begin
                     r_beat    <= '0;
                     resp_last <= 1'b0;
                     resp_data <= r_mem[r_base];
                     r_state   <= S_RD_BURST;
                  end
               end else begin
                  r_lat <= r_lat - LAT_W'(1);
               end
            end
            S_RD_BURST: begin
               if (r_beat == LAST_BEAT) begin
                  resp_valid <= 1'b0;
                  resp_last  <= 1'b0;
                  resp_data  <= '0;
                  r_beat     <= '0;
                  r_state    <= S_IDLE;
               end else begin
                  r_beat    <= w_next_beat;
                  resp_data <= r_mem[w_next_addr];
                  resp_last <= (w_next_beat == LAST_BEAT);
               end
            end
            S_WR_ACK: begin
               resp_valid <= 1'b0;
               resp_last  <= 1'b0;
               resp_data  <= '0;
               r_state    <= S_IDLE;
            end
            default: begin
               resp_valid <= 1'b0;
               resp_last  <= 1'b0;
               resp_data  <= '0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder at LINE_WORDS = 4, LATENCY = 3, DEPTH_LOG2 = 10.
module tb_main_mem_responder;

   localparam int unsigned DL = 10;
   localparam logic [3:0][31:0] INIT4 = {4{32'hDEADBEEF}};
   localparam logic [3:0][31:0] SEQ4  = {32'd4, 32'd3, 32'd2, 32'd1};
   localparam logic [3:0][31:0] PART4 = {32'hDEADBEEF, 32'hDEADBEEF, 32'h0000_00A1, 32'h0000_00A0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] wdata = '0;
   logic        wdata_valid = 1'b0;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_last;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   main_mem_responder #(
      .DEPTH_LOG2(DL), .LINE_WORDS(4), .LATENCY(3), .INIT_WORD(32'hDEADBEEF)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
      .wdata(wdata), .wdata_valid(wdata_valid),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge right after the accepting edge.
   task automatic accept(input bit wr, input logic [31:0] addr, input bit hold);
      chk("ready_before_accept", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      chk("ready_after_accept", 32'(req_ready), 32'd0);
      chk("busy_after_accept", 32'(busy), 32'd1);
   endtask

   // Checks latency gap, the four beats, and the return to IDLE.
   task automatic burst(input logic [3:0][31:0] d, input bit pulse_wd);
      for (int t = 1; t <= 2; t++) begin
         if (pulse_wd) begin
            wdata_valid = 1'b1;
            wdata       = 32'hFFFF_FFFF;
         end
         @(negedge clk);
         wdata_valid = 1'b0;
         chk("wait_valid", 32'(resp_valid), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("beat%0d_valid", i), 32'(resp_valid), 32'd1);
         chk($sformatf("beat%0d_data", i), resp_data, d[i]);
         chk($sformatf("beat%0d_last", i), 32'(resp_last), (i == 3) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      chk("post_valid", 32'(resp_valid), 32'd0);
      chk("post_data", resp_data, 32'd0);
      chk("post_ready", 32'(req_ready), 32'd1);
      chk("post_busy", 32'(busy), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [3:0][31:0] d, input bit pulse_wd);
      accept(1'b0, addr, 1'b0);
      burst(d, pulse_wd);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [3:0][31:0] d, input bit gap);
      accept(1'b1, addr, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (gap && i == 2) begin
            wdata_valid = 1'b0;
            wdata       = 32'hBAD0_BAD0;
            @(negedge clk);
            chk("gap_valid", 32'(resp_valid), 32'd0);
            chk("gap_busy", 32'(busy), 32'd1);
         end
         wdata_valid = 1'b1;
         wdata       = d[i];
         @(negedge clk);
      end
      wdata_valid = 1'b0;
      for (int t = 1; t <= 2; t++) begin
         @(negedge clk);
         chk("wr_wait_valid", 32'(resp_valid), 32'd0);
      end
      @(negedge clk);
      chk("ack_valid", 32'(resp_valid), 32'd1);
      chk("ack_last", 32'(resp_last), 32'd1);
      chk("ack_data", resp_data, 32'd0);
      @(negedge clk);
      chk("ack_post_valid", 32'(resp_valid), 32'd0);
      chk("ack_post_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_last", 32'(resp_last), 32'd0);
      chk("rst_data", resp_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Untouched memory reads the init word
      do_read(32'h100, INIT4, 1'b0);

      // Write with a gap, then read back aligned, unaligned and aliased
      do_write(32'h200, SEQ4, 1'b1);
      do_read(32'h200, SEQ4, 1'b0);
      do_read(32'h20C, SEQ4, 1'b0);
      do_read(32'h200 + (32'd4 << DL), SEQ4, 1'b0);

      // Held request: second accepted after resp_last plus one IDLE cycle
      accept(1'b0, 32'h200, 1'b1);
      req_addr = 32'h300;
      burst(SEQ4, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("held_ready_after", 32'(req_ready), 32'd0);
      chk("held_busy_after", 32'(busy), 32'd1);
      burst(INIT4, 1'b0);

      // Reset after the second read beat
      accept(1'b0, 32'h200, 1'b0);
      repeat (4) @(negedge clk);
      chk("pre_rst_beat1", resp_data, 32'd2);
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(resp_valid), 32'd0);
      chk("midrst_last", 32'(resp_last), 32'd0);
      chk("midrst_data", resp_data, 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      do_read(32'h200, SEQ4, 1'b0);

      // Reset during WR_DATA after two stored beats
      accept(1'b1, 32'h100, 1'b0);
      wdata_valid = 1'b1;
      wdata       = 32'h0000_00A0;
      @(negedge clk);
      wdata       = 32'h0000_00A1;
      @(negedge clk);
      wdata_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_read(32'h100, PART4, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Backing-memory responder on the far side of the cache refill interface.
- Accepts line-granular read (refill) and write (writeback) requests from the cache controller over a valid/ready handshake.
- Models a fixed access latency, then returns read data as a LINE_WORDS-word burst or returns a single write acknowledge.
- Serves as the synthesizable main-memory model used by cache and system testbenches.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words.
- LINE_WORDS, 4, words per cache line; power of two, at least 2.
- LATENCY, 3, cycles from request accept to first response beat; at least 1.
- INIT_WORD, 32'hDEADBEEF, value of every memory word at time zero.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_wr  in  1  1 = line write, 0 = line read; sampled at accept.
- req_addr  in  32  byte address; sampled at accept.
- wdata  in  32  write beat data.
- wdata_valid  in  1  write beat present; consumed only in WR_DATA.
- resp_valid  out  1  response beat.
- resp_data  out  32  read beat data; 0 on a write ack.
- resp_last  out  1  final beat of a read burst, or the write ack.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state IDLE, all counters 0, resp_valid/resp_last/busy 0, resp_data 0. req_ready is high as soon as rst deasserts.
- Reset does not alter memory contents. A write aborted by reset keeps the beats already stored.
- Address mapping: word index = req_addr[DEPTH_LOG2+1:2] with the low log2(LINE_WORDS) bits forced to 0 (line-aligned). Higher address bits are ignored, so addresses alias.
- Accept occurs on an edge where state = IDLE and req_valid = 1. Address and req_wr are latched; the latched values hold until the operation completes.
- States: IDLE, WR_DATA, WAIT, RD_BURST, WR_ACK.
- IDLE, accepted read: go to WAIT, latency counter = LATENCY-1.
- IDLE, accepted write: go to WR_DATA, beat counter = 0.
- WR_DATA: on each edge with wdata_valid = 1, store wdata at line base + beat counter and increment the counter. A gap in wdata_valid stalls with no store. After beat LINE_WORDS-1 is stored, go to WAIT with counter = LATENCY-1.
- WAIT: decrement each edge. At 0, go to RD_BURST for a read or WR_ACK for a write.
- With LATENCY = 1, WAIT lasts exactly 1 cycle.
- Read timing: accept at edge k gives the first resp_valid in the cycle following edge k+LATENCY.
- RD_BURST: resp_valid = 1 for exactly LINE_WORDS consecutive cycles, with no backpressure. resp_data = mem[base+i] for i = 0..LINE_WORDS-1 in order. resp_last = 1 on beat LINE_WORDS-1 only. Then go to IDLE.
- WR_ACK: one cycle with resp_valid = 1, resp_last = 1, resp_data = 0. Then go to IDLE.
- All response outputs are registered; outside RD_BURST/WR_ACK, resp_valid and resp_last are 0 and resp_data is 0.
- Back-to-back requests: there is at least one IDLE cycle between resp_last and the next accept. A request held high during busy is accepted on the first IDLE edge.
- wdata_valid outside WR_DATA is ignored. req_valid outside IDLE is ignored; there is no queueing.
- Reset mid-operation: the burst aborts immediately; outputs go to their reset values asynchronously.

Test Plan (defaults: LINE_WORDS = 4, LATENCY = 3):
- Reset, then read at 0x100 -> req_ready drops after accept. Four resp_valid beats of 32'hDEADBEEF, first in the cycle after accept+3 edges, resp_last on beat 4 only, then req_ready = 1.
- Write at 0x200 with words 1, 2, 3, 4, with a one-cycle wdata_valid gap after word 2 -> stall with no store during the gap. Single ack (resp_last = 1, resp_data = 0) 3 edges after the 4th beat. A following read of 0x200 returns 1, 2, 3, 4.
- Read at unaligned 0x20C after the previous write -> same burst 1, 2, 3, 4. Read at 0x200 + (4 << DEPTH_LOG2) -> aliases and returns 1, 2, 3, 4.
- req_valid held high for two requests -> second accepted only after resp_last plus one IDLE cycle. wdata_valid pulses during the read are ignored and the memory is unchanged.
- Assert rst after the 2nd read beat -> resp_valid/resp_last/resp_data = 0 immediately, busy = 0, req_ready = 1 after deassert. A re-read returns the original data.
- Assert rst during WR_DATA after 2 beats -> re-read shows the 2 new words plus the 2 old words.
